// File: rtl/miriscv_instr_fetch_buffer.sv
// Fetch-side decoupling buffer: forwards fetch requests to a pipelined
// req/gnt/rvalid instruction bus and holds returned words in order until
// the fetch stage takes them. On flush, buffered words and in-flight
// responses are discarded.
module miriscv_instr_fetch_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_req_i,
  input  logic [XLEN-1:0] core_addr_i,
  output logic            core_gnt_o,
  input  logic            core_flush_i,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  input  logic            core_rready_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fifo_q [DEPTH];
  logic [XLEN-1:0] fifo_d [DEPTH];

  logic space, grant, drop, deliver, fifo_empty, push, pop;

  // Credit: a request is only issued if its response is sure to find a slot.
  assign fifo_empty = (fifo_cnt_q == '0);
  assign space      = (SW'(out_cnt_q) + SW'(fifo_cnt_q)) < SW'(DEPTH);

  assign mem_req_o  = core_req_i & space & ~core_flush_i & ~rst_i;
  assign mem_addr_o = core_addr_i;
  assign grant      = mem_req_o & mem_gnt_i;
  assign core_gnt_o = grant;

  // A response is discarded while older flushed requests are still draining
  // or when it coincides with a flush.
  assign drop    = mem_rvalid_i & ((drop_cnt_q != '0) | core_flush_i);
  assign deliver = mem_rvalid_i & ~drop;

  // Empty FIFO bypasses the bus word straight through; otherwise the head leads.
  assign core_rvalid_o = ~core_flush_i & ~rst_i & (~fifo_empty | deliver);
  assign core_rdata_o  = fifo_empty ? mem_rdata_i : fifo_q[rd_ptr_q];

  assign push = deliver & (~fifo_empty | ~core_rready_i);
  assign pop  = core_rvalid_o & core_rready_i & ~fifo_empty;

  // Next-state for counters, pointers and storage.
  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(grant) - CW'(mem_rvalid_i);
    drop_cnt_d = drop_cnt_q - CW'(mem_rvalid_i && (drop_cnt_q != '0));
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    fifo_d     = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata_i;
    end
    if (core_flush_i) begin
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = out_cnt_d;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Word storage needs no reset; occupancy is tracked by fifo_cnt_q.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_miriscv_instr_fetch_buffer.sv
// Self-checking bench: a memory model with random in-order latency and a
// queue-based reference of which words the fetch stage must see.
module tb_miriscv_instr_fetch_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            core_req_i;
  logic [XLEN-1:0] core_addr_i;
  logic            core_gnt_o;
  logic            core_flush_i;
  logic            core_rvalid_o;
  logic [XLEN-1:0] core_rdata_o;
  logic            core_rready_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  miriscv_instr_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .core_req_i    (core_req_i),
    .core_addr_i   (core_addr_i),
    .core_gnt_o    (core_gnt_o),
    .core_flush_i  (core_flush_i),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .core_rready_i (core_rready_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          epoch;
  } resp_t;

  resp_t       mem_q[$];   // granted requests awaiting their response
  logic [31:0] buf_q[$];   // returned live words not yet consumed

  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          n_grants = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic        last_rv, last_req;
  logic [31:0] last_data;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs, let memory answer, compare against the model.
  task automatic step(input logic req, input logic [31:0] addr, input logic flush,
                      input logic rready, input logic gnt);
    resp_t       w;
    logic        have_w, live, exp_rv, exp_req;
    logic [31:0] exp_data;
    int          infl;
    core_req_i    = req;
    core_addr_i   = addr;
    core_flush_i  = flush;
    core_rready_i = rready;
    mem_gnt_i     = gnt;
    infl          = mem_q.size();
    have_w        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (have_w) begin
      w            = mem_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = w.data;
    end else begin
      w            = '{data: 32'h0, due: 0, epoch: -1};
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
    end
    #1;
    live     = have_w && (w.epoch == epoch) && !flush;
    exp_rv   = !flush && ((buf_q.size() > 0) || live);
    exp_req  = req && !flush && ((infl + buf_q.size()) < DEPTH);
    exp_data = (buf_q.size() > 0) ? buf_q[0] : w.data;
    last_rv   = core_rvalid_o;
    last_req  = mem_req_o;
    last_data = core_rdata_o;
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    chk("core_gnt", 32'(core_gnt_o), 32'(exp_req && gnt));
    chk("core_rvalid", 32'(core_rvalid_o), 32'(exp_rv));
    if (exp_rv) chk("core_rdata", core_rdata_o, exp_data);
    if (exp_req) chk("mem_addr", mem_addr_o, addr);
    if (live) buf_q.push_back(w.data);
    if (exp_rv && rready) void'(buf_q.pop_front());
    if (flush) begin
      buf_q.delete();
      epoch++;
    end
    if (exp_req && gnt) begin
      mem_q.push_back('{data: word_at(addr), due: cyc + int'($urandom_range(lat_max, lat_min)),
                        epoch: epoch});
      n_grants++;
      chk("inflight_bound", 32'(mem_q.size() + buf_q.size() <= DEPTH), 32'd1);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    core_req_i    = 1'b1;
    core_flush_i  = 1'b0;
    core_rready_i = 1'b1;
    mem_gnt_i     = 1'b1;
    mem_rvalid_i  = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_core_gnt", 32'(core_gnt_o), 32'd0);
    chk("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_q.delete();
    buf_q.delete();
    cyc++;
  endtask

  initial begin
    rst_i = 1'b1; core_req_i = 1'b0; core_addr_i = '0; core_flush_i = 1'b0;
    core_rready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();

    // Single fetch, latency 1
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    chk("single_gnt", 32'(last_req), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("single_rvalid", 32'(last_rv), 32'd1);
    chk("single_data", last_data, 32'h0000_0093);

    // Back-pressure: fill both slots, then drain in order
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    chk("bp_blocked", 32'(last_req), 32'd0);
    step(1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
    chk("bp_first", last_data, word_at(32'h0));
    step(1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
    chk("bp_second", last_data, word_at(32'h4));
    chk("bp_req_back", 32'(last_req), 32'd1);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Flush with two requests in flight, then fetch 0x200
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    lat_min = 1; lat_max = 1;
    repeat (2) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("flush_no_rvalid", 32'(last_rv), 32'd0);
    end
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("post_flush_data", last_data, word_at(32'h200));

    // Flush coinciding with rvalid
    step(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("flush_rv_drop", 32'(last_rv), 32'd0);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Random latency 1-4 with random ready and flushes
    lat_min = 1; lat_max = 4;
    n_grants = 0;
    for (int c = 0; c < 20000 && n_grants < 1000; c++) begin
      step($urandom_range(99) < 80, $urandom() & 32'hFFFF_FFFC, $urandom_range(99) < 5,
           1'($urandom_range(1)), $urandom_range(99) < 75);
    end
    chk("random_grants", 32'(n_grants >= 1000), 32'd1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Reset mid-stream
    lat_min = 2; lat_max = 2;
    step(1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h404, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h408, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("post_rst_rvalid", 32'(last_rv), 32'd0);
    step(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    chk("post_rst_req", 32'(last_req), 32'd1);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
